// File: rtl/cpu_pkg.sv
// Shared definitions for the memory port arbiter.
//  - arb_state_t : 2-bit arbiter FSM encoding (IDLE / ACCESS / DONE)
//  - OWNER_IF / OWNER_MEM : which pipeline stage owns the current access
//  - DEF_AW / DEF_DW : default address and data widths
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog for the memory port arbiter.
// Counts cycles spent waiting for mem_ready and flags the last allowed cycle.
// Ports:
//  clk       in  clock
//  rst_n     in  synchronous active-low reset
//  i_clr     in  clear count (asserted on every grant)
//  i_en      in  count enable (asserted while in ACCESS)
//  o_expired out high in the TIMEOUT-th enabled cycle since the last clear
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The first ACCESS cycle sees count 0, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between instruction fetch (IF) and
// the MEM stage (lw/sw). Each access runs IDLE -> ACCESS -> DONE; the owner
// gets a one-cycle valid pulse in DONE. Stall outputs feed the hazard unit.
// Ports:
//  clk, rst_n                     clock, synchronous active-low reset
//  if_req/if_addr                 fetch request (level) and address
//  if_rdata/if_valid              fetched word and completion pulse
//  dm_read/dm_write/dm_addr/dm_wdata  load/store request from MEM stage
//  dm_rdata/dm_valid              load data and completion pulse
//  mem_req/mem_we/mem_addr/mem_wdata  memory-side request (latched)
//  mem_rdata/mem_ready            memory-side response
//  stall_if/stall_mem             combinational stall requests
//  bus_err                        sticky timeout flag
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MEM_BURST = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          bus_err
);

  localparam int BW = $clog2(MEM_BURST + 1);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;
  logic          r_bus_err;
  logic [BW-1:0] r_burst;

  logic w_mem_pend;
  logic w_grant_mem;
  logic w_grant_if;
  logic w_grant;
  logic w_in_access;
  logic w_expired;

  assign w_mem_pend  = dm_read | dm_write;
  assign w_in_access = (r_state == ARB_ACCESS);
  assign w_grant     = w_grant_mem | w_grant_if;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // MEM normally wins; after MEM_BURST back-to-back MEM grants with a fetch
  // waiting, IF gets the next slot. DONE never arbitrates, so a request that
  // is still held during its own valid pulse is not issued twice.
  always_comb begin
    w_next      = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_mem_pend && ((r_burst < BW'(MEM_BURST)) || !if_req)) begin
          w_grant_mem = 1'b1;
        end else if (if_req) begin
          w_grant_if = 1'b1;
        end
        if (w_grant_mem || w_grant_if) begin
          w_next = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (mem_ready || w_expired) begin
          w_next = ARB_DONE;
        end
      end
      ARB_DONE: w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner    <= OWNER_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_bus_err  <= 1'b0;
      r_burst    <= '0;
    end else begin
      if (w_grant_mem) begin
        r_owner <= OWNER_MEM;
        r_addr  <= dm_addr;
        r_wdata <= dm_wdata;
        // Simultaneous read and write is treated as a write.
        r_we    <= dm_write;
        // Grant is only possible with if_req high while below MEM_BURST.
        r_burst <= if_req ? (r_burst + BW'(1)) : '0;
      end else if (w_grant_if) begin
        r_owner <= OWNER_IF;
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_burst <= '0;
      end

      // Ready wins over expiry in the last allowed cycle. Writes leave the
      // owner's read data untouched whether they complete or time out.
      if (w_in_access) begin
        if (mem_ready) begin
          if (!r_we) begin
            if (r_owner == OWNER_MEM) r_dm_rdata <= mem_rdata;
            else                      r_if_rdata <= mem_rdata;
          end
        end else if (w_expired) begin
          r_bus_err <= 1'b1;
          if (!r_we) begin
            if (r_owner == OWNER_MEM) r_dm_rdata <= '0;
            else                      r_if_rdata <= '0;
          end
        end
      end
    end
  end

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_grant),
    .i_en      (w_in_access),
    .o_expired (w_expired)
  );

  assign mem_req   = w_in_access;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_valid  = (r_state == ARB_DONE) && (r_owner == OWNER_IF);
  assign dm_valid  = (r_state == ARB_DONE) && (r_owner == OWNER_MEM);
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = w_mem_pend & ~dm_valid;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  mem_port_arbiter #(
    .AW(32), .DW(32), .MEM_BURST(4), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Memory responder: asserts ready in the (rsp_delay+1)-th request cycle.
  int          rsp_delay = 0;
  logic        rsp_never = 1'b0;
  logic [31:0] rsp_data  = '0;
  int          acc_cnt   = 0;

  always @(negedge clk) begin
    if (mem_req) begin
      mem_ready = !rsp_never && (acc_cnt >= rsp_delay);
      mem_rdata = rsp_data;
      acc_cnt   = acc_cnt + 1;
    end else begin
      mem_ready = 1'b0;
      acc_cnt   = 0;
    end
  end

  // Monitor: grant log (address of each new request) and valid pulse counts.
  logic [31:0] glog[$];
  logic        prev_req  = 1'b0;
  int          n_dmv     = 0;
  int          n_overlap = 0;

  always @(negedge clk) begin
    if (if_valid && dm_valid) n_overlap++;
    if (dm_valid) n_dmv++;
    if (mem_req && !prev_req) glog.push_back(mem_addr);
    prev_req = mem_req;
  end

  typedef struct {
    logic        is_mem;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    int          dly;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[6];
  vec_t        v;
  logic [31:0] exp3[6];
  int          lat;
  int          cyc;
  int          nacc;
  int          base;
  int          v_cnt;
  logic        seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //               mem  rd  wr  addr         wdata         rsp           dly exp_addr     we  exp_rdata     lat
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 32'h10, 1'b0, 32'hDEADBEEF, 2};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 2, 32'h20, 1'b0, 32'hCAFEF00D, 4};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h40, 32'h12345678, 32'hBAD0BAD0, 1, 32'h40, 1'b1, 32'hCAFEF00D, 3};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 32'h44, 1'b1, 32'hCAFEF00D, 2};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h14, 32'h0,        32'h00000013, 3, 32'h14, 1'b0, 32'h00000013, 5};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h48, 32'h0,        32'h0F0F0F0F, 0, 32'h48, 1'b0, 32'h0F0F0F0F, 2};
    exp3 = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

    // Reset state
    repeat (3) tick;
    chk("rst_mem_req",   32'(mem_req),  32'd0);
    chk("rst_mem_we",    32'(mem_we),   32'd0);
    chk("rst_if_valid",  32'(if_valid), 32'd0);
    chk("rst_dm_valid",  32'(dm_valid), 32'd0);
    chk("rst_bus_err",   32'(bus_err),  32'd0);
    chk("rst_if_rdata",  if_rdata,  32'd0);
    chk("rst_dm_rdata",  dm_rdata,  32'd0);
    chk("rst_mem_addr",  mem_addr,  32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    tick;

    // Single transactions from the vector table
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      rsp_delay = v.dly; rsp_data = v.rsp; rsp_never = 1'b0;
      if_req = !v.is_mem; if_addr = v.addr;
      dm_read = v.rd; dm_write = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
      #1;
      if (v.is_mem) chk($sformatf("v%0d_stall_mem_req", i), 32'(stall_mem), 32'd1);
      else          chk($sformatf("v%0d_stall_if_req", i),  32'(stall_if),  32'd1);
      lat = 0; seen = 1'b0;
      while (!seen && lat < 40) begin
        tick; lat++;
        if (mem_req) begin
          chk($sformatf("v%0d_mem_addr", i), mem_addr, v.exp_addr);
          chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(v.exp_we));
          if (v.exp_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.wdata);
          // Inputs change while granted; latched values must persist.
          if_addr = 32'hFFFFFFF0; dm_addr = 32'hFFFFFFF0; dm_wdata = ~v.wdata;
        end
        seen = v.is_mem ? dm_valid : if_valid;
      end
      if (!seen) begin
        bound_fail($sformatf("v%0d_valid", i));
      end else begin
        chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
        if (v.is_mem) begin
          chk($sformatf("v%0d_dm_rdata", i), dm_rdata, v.exp_rdata);
          chk($sformatf("v%0d_stall_mem_done", i), 32'(stall_mem), 32'd0);
          chk($sformatf("v%0d_if_valid_quiet", i), 32'(if_valid), 32'd0);
        end else begin
          chk($sformatf("v%0d_if_rdata", i), if_rdata, v.exp_rdata);
          chk($sformatf("v%0d_stall_if_done", i), 32'(stall_if), 32'd0);
          chk($sformatf("v%0d_dm_valid_quiet", i), 32'(dm_valid), 32'd0);
        end
      end
      if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
      tick; tick;
    end

    // Simultaneous IF and MEM: MEM first, IF granted in the cycle after DONE
    rsp_delay = 3; rsp_data = 32'h11111111; rsp_never = 1'b0;
    if_req = 1'b1; if_addr = 32'h100; dm_read = 1'b1; dm_addr = 32'h200;
    tick;
    chk("t2_first_req", 32'(mem_req), 32'd1);
    chk("t2_first_owner_addr", mem_addr, 32'h200);
    cyc = 0;
    while (!dm_valid && cyc < 20) begin tick; cyc++; end
    if (!dm_valid) bound_fail("t2_dm_valid");
    chk("t2_dm_rdata", dm_rdata, 32'h11111111);
    chk("t2_if_valid_during_dm", 32'(if_valid), 32'd0);
    chk("t2_stall_if_held", 32'(stall_if), 32'd1);
    dm_read = 1'b0; rsp_data = 32'h22222222;
    tick;
    chk("t2_gap_no_req", 32'(mem_req), 32'd0);
    tick;
    chk("t2_if_req_issued", 32'(mem_req), 32'd1);
    chk("t2_if_addr", mem_addr, 32'h100);
    cyc = 0;
    while (!if_valid && cyc < 20) begin tick; cyc++; end
    if (!if_valid) bound_fail("t2_if_valid");
    chk("t2_if_rdata", if_rdata, 32'h22222222);
    if_req = 1'b0;
    tick; tick;
    chk("t2_no_overlap", 32'(n_overlap), 32'd0);

    // Fairness: MEM held continuously with IF pending
    rsp_delay = 0; rsp_data = 32'h33333333;
    base = glog.size();
    if_req = 1'b1; if_addr = 32'h300; dm_read = 1'b1; dm_addr = 32'h400;
    cyc = 0;
    while (glog.size() < base + 6 && cyc < 80) begin tick; cyc++; end
    if_req = 1'b0; dm_read = 1'b0;
    repeat (6) tick;
    if (glog.size() < base + 6) begin
      bound_fail("t3_grants");
    end else begin
      for (int k = 0; k < 6; k++) chk($sformatf("t3_grant%0d", k), glog[base + k], exp3[k]);
    end
    chk("t3_no_overlap", 32'(n_overlap), 32'd0);

    // Timeout on a read, then normal service continues
    rsp_never = 1'b1;
    dm_read = 1'b1; dm_addr = 32'h500;
    tick;
    chk("t5_req", 32'(mem_req), 32'd1);
    chk("t5_bus_err_before", 32'(bus_err), 32'd0);
    nacc = 1; cyc = 0;
    while (!dm_valid && cyc < 40) begin
      tick; cyc++;
      if (mem_req) nacc++;
    end
    if (!dm_valid) bound_fail("t5_dm_valid");
    chk("t5_access_cycles", 32'(nacc), 32'(TOUT));
    chk("t5_bus_err", 32'(bus_err), 32'd1);
    chk("t5_dm_rdata_zero", dm_rdata, 32'd0);
    dm_read = 1'b0; rsp_never = 1'b0; rsp_delay = 0; rsp_data = 32'h77;
    tick;
    if_req = 1'b1; if_addr = 32'h18;
    cyc = 0;
    while (!if_valid && cyc < 20) begin tick; cyc++; end
    if (!if_valid) bound_fail("t5_if_valid");
    chk("t5_after_if_rdata", if_rdata, 32'h77);
    chk("t5_bus_err_sticky", 32'(bus_err), 32'd1);
    if_req = 1'b0;
    tick; tick;

    // Reset in the middle of an access
    rsp_never = 1'b1;
    dm_read = 1'b1; dm_addr = 32'h600;
    tick;
    chk("t6_req1", 32'(mem_req), 32'd1);
    tick;
    chk("t6_req2", 32'(mem_req), 32'd1);
    v_cnt = n_dmv;
    rst_n = 1'b0;
    tick;
    chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t6_rst_dm_valid", 32'(dm_valid), 32'd0);
    chk("t6_rst_bus_err", 32'(bus_err), 32'd0);
    chk("t6_rst_mem_addr", mem_addr, 32'd0);
    chk("t6_rst_dm_rdata", dm_rdata, 32'd0);
    rst_n = 1'b1; rsp_never = 1'b0; rsp_delay = 0; rsp_data = 32'h66;
    tick;
    chk("t6_regrant", 32'(mem_req), 32'd1);
    chk("t6_regrant_addr", mem_addr, 32'h600);
    chk("t6_no_pulse", 32'(n_dmv), 32'(v_cnt));
    cyc = 0;
    while (!dm_valid && cyc < 20) begin tick; cyc++; end
    if (!dm_valid) bound_fail("t6_dm_valid");
    chk("t6_dm_rdata", dm_rdata, 32'h66);
    dm_read = 1'b0;
    tick; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
